// File: rtl/skid_buf_pkg.sv
// skid_buf shared definitions: state encodings and default width.
// Imported by the interface, the data register and the top.
package skid_buf_pkg;

    localparam int DATA_W = 32;

    // Encoding follows the valid bits: bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_ONE   = 2'b01,
        SB_FULL  = 2'b11
    } sb_state_e;

endpackage

// File: rtl/skid_buf_if.sv
// skid_buf handshake bundle: upstream in_* and downstream out_* signals.
// slave = buffer view, master = surrounding stages / bench view.
interface skid_buf_if
    import skid_buf_pkg::*;
#(
    parameter int SIZE = DATA_W
) ();

    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/skid_buf_dreg.sv
// dreg: SIZE-bit data register with load enable and synchronous clear.
// Ports: clk, clr (active-high, sync), en, d in; q out.
module dreg
    import skid_buf_pkg::*;
#(
    parameter int SIZE = DATA_W
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buf.sv
// skid_buf: registered valid/ready pipeline buffer with one skid entry.
// Ports: clk, rst (sync, active-high), flush; bus = in_*/out_* handshake.
module skid_buf
    import skid_buf_pkg::*;
#(
    parameter int SIZE = DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    skid_buf_if.slave  bus
);

    sb_state_e       state_q;
    sb_state_e       state_d;
    logic            in_ready_q;
    logic            accept;
    logic            drain;
    logic            main_en;
    logic            skid_en;
    logic [SIZE-1:0] main_d;
    logic [SIZE-1:0] main_q;
    logic [SIZE-1:0] skid_q;

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = (state_q != SB_EMPTY) & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SB_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Registered so upstream never sees a path from out_ready.
            in_ready_q <= (state_d != SB_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in_data;
        unique case (state_q)
            SB_EMPTY: begin
                if (accept) begin
                    state_d = SB_ONE;
                    main_en = 1'b1;
                end
            end
            SB_ONE: begin
                if (accept && drain) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = SB_FULL;
                    skid_en = 1'b1;
                end else if (drain) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_FULL: begin
                // in_ready is low here, so only a drain can occur.
                if (drain) begin
                    state_d = SB_ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = SB_EMPTY;
            end
        endcase
        // Flush drops everything, including a word offered this cycle.
        if (flush) begin
            state_d = SB_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    dreg #(.SIZE(SIZE)) u_main (
        .clk (clk),
        .clr (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    dreg #(.SIZE(SIZE)) u_skid (
        .clk (clk),
        .clr (rst),
        .en  (skid_en),
        .d   (bus.in_data),
        .q   (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != SB_EMPTY);
    assign bus.out_data  = main_q;

endmodule

// File: tb/tb_skid_buf.sv
// skid_buf bench: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_skid_buf;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    skid_buf_if #(.SIZE(32)) bus ();

    skid_buf #(.SIZE(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    logic [31:0] m_main = '0;
    bit          m_ready = 1'b1;
    bit          armed = 1'b0;
    logic [31:0] olog[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two words; the head is what the
    // main register shows, ready means room remains after the edge.
    always @(posedge clk) begin
        bit acc;
        bit drn;
        if (bus.out_valid === 1'b1 && bus.out_ready && !rst && !flush)
            olog.push_back(bus.out_data);
        acc = bus.in_valid && m_ready;
        drn = (mq.size() > 0) && bus.out_ready;
        if (rst) begin
            mq.delete();
            m_main = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(bus.in_data);
            if (mq.size() > 0) m_main = mq[0];
        end
        m_ready = (mq.size() < 2);
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
            chk("out_data", bus.out_data, m_main);
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit ordy,
                       input bit fl, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = r;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input bit ov, input logic [31:0] od,
                       input bit ir);
        chk({nm, "_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
        chk({nm, "_data"}, bus.out_data, od);
        chk({nm, "_ready"}, {31'd0, bus.in_ready}, {31'd0, ir});
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst           = 1'b1;

        // Reset held with a word offered.
        cyc(1, 32'hDEADBEEF, 0, 0, 1);
        lit("rst0", 0, 32'h0, 1);
        cyc(1, 32'hDEADBEEF, 0, 0, 1);
        lit("rst1", 0, 32'h0, 1);
        cyc(0, 32'h0, 0, 0, 0);
        lit("rst_rel", 0, 32'h0, 1);

        // Streaming 1..8 at full rate.
        olog.delete();
        for (int i = 1; i <= 8; i++) begin
            cyc(1, i, 1, 0, 0);
            lit("stream", 1, i, 1);
        end
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0, 0);
        chk("stream_cnt", olog.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("stream_word", (i < olog.size()) ? olog[i] : 32'hx, i + 1);
        lit("drained_keeps", 0, 32'd8, 1);

        // Stall: A in main, B in skid, C held upstream.
        olog.delete();
        cyc(1, 32'hA, 0, 0, 0);
        lit("stall_a", 1, 32'hA, 1);
        cyc(1, 32'hB, 0, 0, 0);
        lit("stall_b", 1, 32'hA, 0);
        cyc(1, 32'hC, 0, 0, 0);
        lit("stall_c", 1, 32'hA, 0);
        cyc(1, 32'hC, 1, 0, 0);
        lit("restart", 1, 32'hB, 1);
        cyc(1, 32'hC, 1, 0, 0);
        lit("restart_c", 1, 32'hC, 1);
        for (int i = 0; i < 2; i++) cyc(0, 32'h0, 1, 0, 0);
        chk("stall_cnt", olog.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("stall_word", (i < olog.size()) ? olog[i] : 32'hx, 32'hA + i);

        // Flush in FULL with a word offered.
        olog.delete();
        cyc(1, 32'h11, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0);
        cyc(1, 32'hBAD, 0, 1, 0);
        lit("flush_full", 0, 32'h11, 1);
        // Flush in ONE with a real accept pending.
        cyc(1, 32'h33, 0, 0, 0);
        cyc(1, 32'hBAD, 0, 1, 0);
        lit("flush_one", 0, 32'h33, 1);
        for (int i = 0; i < 2; i++) cyc(0, 32'h0, 1, 0, 0);
        chk("flush_cnt", olog.size(), 0);

        // Simultaneous accept and drain in ONE.
        cyc(1, 32'h44, 0, 0, 0);
        cyc(1, 32'h55, 1, 0, 0);
        lit("acc_drn", 1, 32'h55, 1);
        cyc(0, 32'h0, 1, 0, 0);

        // Reset while FULL.
        cyc(1, 32'h66, 0, 0, 0);
        cyc(1, 32'h77, 0, 0, 0);
        cyc(1, 32'h88, 0, 0, 1);
        lit("rst_full", 0, 32'h0, 1);
        cyc(1, 32'h99, 0, 0, 0);
        lit("rst_next", 1, 32'h99, 1);
        cyc(0, 32'h0, 1, 0, 0);
        lit("rst_alone", 0, 32'h99, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 149) == 0);
        end
        cyc(0, 32'h0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
